// File: rtl/calc_sequencer.sv
// calc_sequencer: push-button driven sequencer for a multi-cycle calculator
// datapath. One button walks GET_A -> GET_B -> GET_OP -> COMPUTE -> SHOW/ERROR
// and back to GET_A. The button is synchronized, optionally debounced and
// edge-detected. All outputs are registered.
//
// Optional feature: define CALC_SEQ_DEBOUNCE_EN to insert a DEBOUNCE_CYCLES
// stable-count debouncer after the synchronizer. In the default build the
// debounced level is the synchronized level and no debounce logic exists.
module calc_sequencer #(
  parameter int TIMEOUT_CYCLES  = 255,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       button,
  input  logic       done,
  output logic       save_A,
  output logic       save_B,
  output logic       save_op,
  output logic       start,
  output logic       show_result,
  output logic       error,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    GET_A   = 3'd0,
    GET_B   = 3'd1,
    GET_OP  = 3'd2,
    COMPUTE = 3'd3,
    SHOW    = 3'd4,
    ERROR   = 3'd5
  } state_t;

  localparam int            TW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] T_FULL = TW'(TIMEOUT_CYCLES);

  // Reject parameter values that would make the counters meaningless.
  if (TIMEOUT_CYCLES < 1 || DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("calc_sequencer: TIMEOUT_CYCLES and DEBOUNCE_CYCLES must be >= 1");
  end

  logic       sync1;
  logic       sync2;
  logic [1:0] sync_vld;

  // Two-flop synchronizer; sync_vld marks when sync2 holds a real button sample
  // rather than its reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      sync_vld <= 2'b00;
    end else begin
      sync1    <= button;
      sync2    <= sync1;
      sync_vld <= {sync_vld[0], 1'b1};
    end
  end

  logic db_level;

`ifdef CALC_SEQ_DEBOUNCE_EN
  localparam int            DW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic [DW-1:0] db_cnt;

  // Debouncer: follow sync2 only after it has differed for DEBOUNCE_CYCLES
  // consecutive cycles; any agreement in between restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_level <= 1'b0;
      db_cnt   <= '0;
    end else if (sync2 != db_level) begin
      if (db_cnt == DB_LAST) begin
        db_level <= sync2;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end else begin
      db_cnt <= '0;
    end
  end
`else
  assign db_level = sync2;
`endif

  logic db_prev;
  logic armed;
  logic press;

  // Rising-edge detector. Presses are accepted only once a genuine low level
  // has been seen, so a button held through reset release is not a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_prev <= 1'b0;
      armed   <= 1'b0;
    end else begin
      db_prev <= db_level;
      armed   <= armed | (sync_vld[1] & ~sync2 & ~db_level);
    end
  end

  assign press = db_level & ~db_prev & armed;

  state_t        state;
  logic [TW-1:0] tmo_cnt;

  assign state_o = state;

  // Main FSM with registered pulse and level outputs.
  always_ff @(posedge clk or negedge rst_n) begin : p_fsm
    state_t nxt;
    if (!rst_n) begin
      state       <= GET_A;
      tmo_cnt     <= '0;
      save_A      <= 1'b0;
      save_B      <= 1'b0;
      save_op     <= 1'b0;
      start       <= 1'b0;
      show_result <= 1'b0;
      error       <= 1'b0;
    end else begin
      // NOTE: nxt is a local temporary, so it is assigned blocking and read in
      // the same pass; every real register below is assigned non-blocking.
      nxt     = state;
      // Pulses default low each cycle, so a pulse lasts exactly one cycle.
      save_A  <= 1'b0;
      save_B  <= 1'b0;
      save_op <= 1'b0;
      start   <= 1'b0;
      case (state)
        GET_A:  if (press) begin nxt = GET_B;  save_A <= 1'b1; end
        GET_B:  if (press) begin nxt = GET_OP; save_B <= 1'b1; end
        GET_OP: if (press) begin
          nxt     = COMPUTE;
          save_op <= 1'b1;
          start   <= 1'b1;
          tmo_cnt <= '0;
        end
        COMPUTE: begin
          // done in the expiry cycle takes priority over the timeout.
          if (done) begin
            nxt = SHOW;
          end else if (tmo_cnt == T_LAST) begin
            nxt     = ERROR;
            tmo_cnt <= T_FULL;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        SHOW, ERROR: if (press) nxt = GET_A;
        default: nxt = GET_A;
      endcase
      state       <= nxt;
      show_result <= (nxt == SHOW);
      error       <= (nxt == ERROR);
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Testbench for calc_sequencer. Two instances share button and reset: u_a with
// the default timeout (255) and u_b with TIMEOUT_CYCLES=8. A behavioural model
// derives the press stream from the raw button history and steps the
// sequencer rules per instance; a monitor compares every cycle, and the
// scenario tasks add targeted checks.
module tb_calc_sequencer;

  localparam int T_A = 255;
  localparam int T_B = 8;
`ifdef CALC_SEQ_DEBOUNCE_EN
  localparam int DEB = 4;
`else
  localparam int DEB = 0;
`endif
  localparam int HOLD = 2 + DEB;
  localparam int GAP  = 6 + DEB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic button = 1'b0;
  logic done_a = 1'b0;
  logic done_b = 1'b0;

  logic a_save_A, a_save_B, a_save_op, a_start, a_show, a_err;
  logic b_save_A, b_save_B, b_save_op, b_start, b_show, b_err;
  logic [2:0] a_state, b_state;
  logic [8:0] a_out, b_out;

  assign a_out = {a_save_A, a_save_B, a_save_op, a_start, a_show, a_err, a_state};
  assign b_out = {b_save_A, b_save_B, b_save_op, b_start, b_show, b_err, b_state};

  calc_sequencer #(.TIMEOUT_CYCLES(T_A), .DEBOUNCE_CYCLES(4)) u_a (
    .clk(clk), .rst_n(rst_n), .button(button), .done(done_a),
    .save_A(a_save_A), .save_B(a_save_B), .save_op(a_save_op), .start(a_start),
    .show_result(a_show), .error(a_err), .state_o(a_state)
  );

  calc_sequencer #(.TIMEOUT_CYCLES(T_B), .DEBOUNCE_CYCLES(4)) u_b (
    .clk(clk), .rst_n(rst_n), .button(button), .done(done_b),
    .save_A(b_save_A), .save_B(b_save_B), .save_op(b_save_op), .start(b_start),
    .show_result(b_show), .error(b_err), .state_o(b_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- behavioural reference model ----------------
  int         k = 0;
  logic       b_km1 = 1'b0, b_km2 = 1'b0;
  logic       zprev = 1'b0, armed_m = 1'b0, dl = 1'b0;
  int         run_len = 0;
  logic       m_y, m_z, m_p, m_d;
  int         m_lim;
  logic [3:0] m_pul;
  int         m_st[2] = '{0, 0};
  int         m_n[2]  = '{0, 0};
  logic [8:0] m_exp[2] = '{9'd0, 9'd0};

  // A press is a rising edge of the (debounced) button level as seen two
  // clocks late through the synchronizer, counted only after a valid low.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      k = 0; b_km1 = 1'b0; b_km2 = 1'b0;
      zprev = 1'b0; armed_m = 1'b0; dl = 1'b0; run_len = 0;
      for (int i = 0; i < 2; i++) begin
        m_st[i] = 0; m_n[i] = 0; m_exp[i] = 9'd0;
      end
    end else begin
      k++;
      m_y = (k >= 3) ? b_km2 : 1'b0;
`ifdef CALC_SEQ_DEBOUNCE_EN
      m_z = dl;
`else
      m_z = m_y;
`endif
      m_p = m_z & ~zprev & armed_m;
      if (k >= 3 && !m_y && !m_z) armed_m = 1'b1;
      zprev = m_z;
`ifdef CALC_SEQ_DEBOUNCE_EN
      if (m_y != dl) begin
        run_len++;
        if (run_len == DEB) begin dl = m_y; run_len = 0; end
      end else begin
        run_len = 0;
      end
`endif
      b_km2 = b_km1;
      b_km1 = button;
      for (int i = 0; i < 2; i++) begin
        m_lim = (i == 0) ? T_A : T_B;
        m_d   = (i == 0) ? done_a : done_b;
        m_pul = 4'b0000;
        case (m_st[i])
          0: if (m_p) begin m_st[i] = 1; m_pul = 4'b1000; end
          1: if (m_p) begin m_st[i] = 2; m_pul = 4'b0100; end
          2: if (m_p) begin m_st[i] = 3; m_pul = 4'b0011; m_n[i] = 0; end
          3: begin
            m_n[i]++;
            if (m_d) m_st[i] = 4;
            else if (m_n[i] == m_lim) m_st[i] = 5;
          end
          default: if (m_p) m_st[i] = 0;
        endcase
        m_exp[i] = {m_pul, m_st[i] == 4, m_st[i] == 5, 3'(m_st[i])};
      end
    end
  end

  // Cycle-by-cycle comparison of both instances against the model.
  initial forever begin
    @(negedge clk);
    checks++;
    if (a_out !== m_exp[0]) begin
      errors++;
      $display("FAIL monitor_a t=%0t got=%b exp=%b", $time, a_out, m_exp[0]);
    end
    checks++;
    if (b_out !== m_exp[1]) begin
      errors++;
      $display("FAIL monitor_b t=%0t got=%b exp=%b", $time, b_out, m_exp[1]);
    end
  end

  // ---------------- stimulus helpers and activity counters ----------------
  int         cyc = 0;
  int         cnt_sa, cnt_sb, cnt_op, cnt_st_a, cnt_st_b;
  int         b_start_cyc, b_err_cyc, a_sa_cyc;
  bit         seen_show;
  logic [2:0] last_a;
  logic [2:0] seq_a[$];

  task automatic clear_stats();
    cnt_sa = 0; cnt_sb = 0; cnt_op = 0; cnt_st_a = 0; cnt_st_b = 0;
    b_start_cyc = -1; b_err_cyc = -1; a_sa_cyc = -1;
    seen_show = 1'b0;
    last_a = a_state;
    seq_a.delete();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      if (a_save_A) begin cnt_sa++; a_sa_cyc = cyc; end
      if (a_save_B) cnt_sb++;
      if (a_save_op) cnt_op++;
      if (a_start) cnt_st_a++;
      if (b_start) begin cnt_st_b++; b_start_cyc = cyc; end
      if (a_show) seen_show = 1'b1;
      if (b_state == 3'd5 && b_err_cyc < 0) b_err_cyc = cyc;
      if (a_state != last_a) begin seq_a.push_back(a_state); last_a = a_state; end
    end
  endtask

  task automatic press(input int hold, input int gap);
    button = 1'b1; run(hold);
    button = 1'b0; run(gap);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    run(2);
    #1 rst_n = 1'b1;
    run(6);
  endtask

  // Hold the button until the start pulse appears; bounded wait.
  task automatic press_until_start();
    bit seen = 1'b0;
    button = 1'b1;
    for (int i = 0; i < 40 && !seen; i++) begin
      run(1);
      if (cnt_st_a > 0) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL start_timeout: start got=0 exp=1 within 40 cycles");
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    run(3);
    checks++;
    if (a_out !== 9'd0) begin errors++; $display("FAIL reset_a got=%b exp=0", a_out); end
    checks++;
    if (b_out !== 9'd0) begin errors++; $display("FAIL reset_b got=%b exp=0", b_out); end
    #1 rst_n = 1'b1;
    run(6);
    checks++;
    if (a_state !== 3'd0) begin errors++; $display("FAIL reset_idle got=%0d exp=0", a_state); end
  endtask

  task automatic test_latency();
    do_reset();
    clear_stats();
    button = 1'b1;
    for (int i = 1; i <= 4 + DEB; i++) begin
      run(1);
      checks++;
      if (a_save_A !== (i == 3 + DEB)) begin
        errors++;
        $display("FAIL latency cycle %0d: save_A got=%b exp=%b", i, a_save_A, i == 3 + DEB);
      end
    end
    button = 1'b0;
    run(GAP);
  endtask

  task automatic test_full_sequence();
    int exp_seq[5] = '{1, 2, 3, 4, 0};
    do_reset();
    clear_stats();
    press(HOLD, GAP);
    press(HOLD, GAP);
    press_until_start();
    button = 1'b0;
    run(9);
    done_a = 1'b1;
    run(1);
    done_a = 1'b0;
    run(4);
    checks++;
    if (a_state !== 3'd4 || a_show !== 1'b1) begin
      errors++; $display("FAIL full_show got state=%0d show=%b exp 4/1", a_state, a_show);
    end
    checks++;
    if (b_state !== 3'd5 || b_err !== 1'b1) begin
      errors++; $display("FAIL timeout_state got state=%0d err=%b exp 5/1", b_state, b_err);
    end
    checks++;
    if (b_err_cyc - b_start_cyc !== T_B) begin
      errors++; $display("FAIL timeout_delay got=%0d exp=%0d", b_err_cyc - b_start_cyc, T_B);
    end
    press(HOLD, GAP);
    checks++;
    if (a_state !== 3'd0 || b_state !== 3'd0) begin
      errors++; $display("FAIL back_to_get_a got a=%0d b=%0d exp 0/0", a_state, b_state);
    end
    checks++;
    if (cnt_sa != 1 || cnt_sb != 1 || cnt_op != 1 || cnt_st_a != 1 || !seen_show) begin
      errors++;
      $display("FAIL pulse_counts got A=%0d B=%0d op=%0d start=%0d show=%b exp 1/1/1/1/1",
               cnt_sa, cnt_sb, cnt_op, cnt_st_a, seen_show);
    end
    checks++;
    if (seq_a.size() != 5) begin
      errors++; $display("FAIL state_seq_len got=%0d exp=5", seq_a.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (seq_a[i] !== 3'(exp_seq[i])) begin
          errors++; $display("FAIL state_seq[%0d] got=%0d exp=%0d", i, seq_a[i], exp_seq[i]);
        end
      end
    end
  endtask

  task automatic test_done_at_expiry();
    do_reset();
    clear_stats();
    done_a = 1'b1; done_b = 1'b1;
    run(2);
    done_a = 1'b0; done_b = 1'b0;
    run(1);
    checks++;
    if (a_state !== 3'd0 || b_state !== 3'd0) begin
      errors++; $display("FAIL done_ignored got a=%0d b=%0d exp 0/0", a_state, b_state);
    end
    press(HOLD, GAP);
    press(HOLD, GAP);
    press_until_start();
    button = 1'b0;
    run(T_B - 1);
    done_a = 1'b1; done_b = 1'b1;
    run(1);
    done_a = 1'b0; done_b = 1'b0;
    checks++;
    if (b_state !== 3'd4 || b_err !== 1'b0 || b_show !== 1'b1) begin
      errors++;
      $display("FAIL done_wins got state=%0d err=%b show=%b exp 4/0/1", b_state, b_err, b_show);
    end
    run(3);
    press(HOLD, GAP);
  endtask

  task automatic test_hold_and_ignore();
    do_reset();
    clear_stats();
    button = 1'b1;
    run(50);
    button = 1'b0;
    run(GAP);
    checks++;
    if (cnt_sa != 1 || a_state !== 3'd1) begin
      errors++; $display("FAIL long_hold got save_A=%0d state=%0d exp 1/1", cnt_sa, a_state);
    end
    press(HOLD, GAP);
    press_until_start();
    button = 1'b0;
    run(3);
    clear_stats();
    press(HOLD, GAP);
    run(4);
    checks++;
    if (a_state !== 3'd3 || cnt_sa + cnt_sb + cnt_op + cnt_st_a != 0 || seen_show) begin
      errors++;
      $display("FAIL compute_press_a got state=%0d pulses=%0d exp 3/0",
               a_state, cnt_sa + cnt_sb + cnt_op + cnt_st_a);
    end
    checks++;
    if (b_state !== 3'd5) begin
      errors++; $display("FAIL press_not_queued got=%0d exp=5", b_state);
    end
    done_a = 1'b1; run(1); done_a = 1'b0;
    run(2);
    press(HOLD, GAP);
  endtask

  task automatic test_reset_in_compute();
    do_reset();
    clear_stats();
    press(HOLD, GAP);
    press(HOLD, GAP);
    press_until_start();
    button = 1'b0;
    run(3);
    @(negedge clk);
    #1 rst_n = 1'b0;
    run(2);
    checks++;
    if (a_out !== 9'd0 || b_out !== 9'd0) begin
      errors++; $display("FAIL reset_abort got a=%b b=%b exp 0/0", a_out, b_out);
    end
    #1 rst_n = 1'b1;
    clear_stats();
    run(20);
    checks++;
    if (cnt_st_a != 0 || cnt_st_b != 0 || a_state !== 3'd0) begin
      errors++;
      $display("FAIL no_restart got start=%0d/%0d state=%0d exp 0/0/0", cnt_st_a, cnt_st_b, a_state);
    end
  endtask

  task automatic test_held_at_reset();
    button = 1'b1;
    do_reset();
    clear_stats();
    run(15);
    checks++;
    if (cnt_sa != 0 || a_state !== 3'd0 || b_state !== 3'd0) begin
      errors++; $display("FAIL held_at_reset got save_A=%0d state=%0d exp 0/0", cnt_sa, a_state);
    end
    button = 1'b0;
    run(GAP);
    press(HOLD, GAP);
    checks++;
    if (cnt_sa != 1 || a_state !== 3'd1) begin
      errors++; $display("FAIL repress got save_A=%0d state=%0d exp 1/1", cnt_sa, a_state);
    end
  endtask

`ifdef CALC_SEQ_DEBOUNCE_EN
  task automatic test_debounce();
    logic pat[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    int c0;
    do_reset();
    clear_stats();
    c0 = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) c0 = cyc;
      button = pat[i];
      run(1);
    end
    run(8);
    button = 1'b0;
    run(GAP);
    checks++;
    if (cnt_sa != 1 || a_sa_cyc - c0 != 3 + DEB) begin
      errors++;
      $display("FAIL debounce got save_A=%0d latency=%0d exp 1/%0d", cnt_sa, a_sa_cyc - c0, 3 + DEB);
    end
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(3) == 0) button = ~button;
      done_a = ($urandom_range(7) == 0);
      done_b = ($urandom_range(7) == 0);
      run(1);
    end
    button = 1'b0; done_a = 1'b0; done_b = 1'b0;
    run(4);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_stats();
    test_reset();
    test_latency();
    test_full_sequence();
    test_done_at_expiry();
    test_hold_and_ignore();
    test_reset_in_compute();
    test_held_at_reset();
`ifdef CALC_SEQ_DEBOUNCE_EN
    test_debounce();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
